// File: rtl/conv_layer_mc.sv
// conv_layer_mc: multi-input/multi-output channel KxK 2D convolution stage.
//
// A raster stream of InChannels-wide pixels is windowed through KernelWidth-1
// line buffers per input channel. Every output channel sums all input channels
// against its own weights, adds a bias, shifts arithmetically right by Shift
// and saturates to WidthOut signed bits. Results leave through a two-stage
// elastic pipeline (S1 = window, S2 = result) with an end-of-frame flag.
//
// Optional feature: define CONV_LAYER_MC_RELU_EN to clamp negative saturated
// results to zero on every output channel.
//
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   valid_i    input pixel valid
//   ready_o    input ready
//   data_i     packed pixel, channel c at [c*WidthIn +: WidthIn] (unsigned)
//   valid_o    output valid
//   ready_i    downstream ready
//   last_o     final output beat of a frame, qualified by valid_o
//   data_o     signed outputs, channel o at [o*WidthOut +: WidthOut]
//   weights_i  signed weights ordered [o][c][row][col], row 0 = oldest line
//   bias_i     signed per-output-channel bias
module conv_layer_mc #(
    parameter int unsigned LineWidthPx  = 160,
    parameter int unsigned LineCountPx  = 120,
    parameter int unsigned InChannels   = 1,
    parameter int unsigned OutChannels  = 1,
    parameter int unsigned WidthIn      = 1,
    parameter int unsigned WeightWidth  = 2,
    parameter int unsigned BiasWidth    = 8,
    parameter int unsigned AccWidth     = 32,
    parameter int unsigned Shift        = 0,
    parameter int unsigned WidthOut     = 8,
    parameter int unsigned KernelWidth  = 3,
    parameter int unsigned Stride       = 1,
    parameter int unsigned StrideOrigin = 0
) (
    input  logic                                                          clk_i,
    input  logic                                                          rst_i,
    input  logic                                                          valid_i,
    output logic                                                          ready_o,
    input  logic [InChannels*WidthIn-1:0]                                 data_i,
    output logic                                                          valid_o,
    input  logic                                                          ready_i,
    output logic                                                          last_o,
    output logic [OutChannels*WidthOut-1:0]                               data_o,
    input  logic [OutChannels*InChannels*KernelWidth*KernelWidth*WeightWidth-1:0] weights_i,
    input  logic [OutChannels*BiasWidth-1:0]                              bias_i
);

    localparam int unsigned K  = KernelWidth;
    localparam int unsigned XW = (LineWidthPx > 1) ? $clog2(LineWidthPx) : 1;
    localparam int unsigned YW = (LineCountPx > 1) ? $clog2(LineCountPx) : 1;
    localparam int unsigned PW = (Stride > 1) ? $clog2(Stride) : 1;

    // Position of the final strided output of a frame.
    localparam int unsigned LastX = K - 1 + ((LineWidthPx - K) / Stride) * Stride;
    localparam int unsigned LastY = K - 1 + ((LineCountPx - K) / Stride) * Stride;

    localparam logic [PW-1:0] PhaseOrg = PW'(StrideOrigin);
    localparam logic [PW-1:0] PhaseMax = PW'(Stride - 1);

    localparam logic signed [AccWidth-1:0] SatMax =
        {{(AccWidth - WidthOut + 1){1'b0}}, {(WidthOut - 1){1'b1}}};
    localparam logic signed [AccWidth-1:0] SatMin = ~SatMax;

    logic [XW-1:0] x_pos;
    logic [YW-1:0] y_pos;
    logic [PW-1:0] x_phase;
    logic [PW-1:0] y_phase;

    // lbuf[c][0] holds the oldest line, lbuf[c][K-2] the previous line.
    logic [WidthIn-1:0] lbuf [InChannels][K-1][LineWidthPx];
    logic [WidthIn-1:0] col  [InChannels][K];
    // The window register doubles as the S1 payload: it only moves on in_fire,
    // and in_fire implies S1 is allowed to load.
    logic [WidthIn-1:0] win  [InChannels][K][K];

    logic valid_s1, last_s1;
    logic valid_s2, last_s2;
    logic [OutChannels*WidthOut-1:0] data_s2;
    logic [OutChannels*WidthOut-1:0] result;

    logic adv2, in_fire, x_end, y_end, kern_ok, produce, at_last;

    assign adv2    = ~valid_s2 | ready_i;
    assign ready_o = ~valid_s1 | adv2;
    assign in_fire = valid_i & ready_o;

    assign x_end   = (x_pos == XW'(LineWidthPx - 1));
    assign y_end   = (y_pos == YW'(LineCountPx - 1));
    assign kern_ok = (x_pos >= XW'(K - 1)) && (y_pos >= YW'(K - 1));
    assign produce = in_fire & kern_ok & (x_phase == PhaseOrg) & (y_phase == PhaseOrg);
    assign at_last = (x_pos == XW'(LastX)) && (y_pos == YW'(LastY));

    // New right-hand window column: buffered lines on top, incoming pixel last.
    always_comb begin
        for (int c = 0; c < InChannels; c++) begin
            for (int r = 0; r < K - 1; r++) begin
                col[c][r] = lbuf[c][r][x_pos];
            end
            col[c][K-1] = data_i[c*WidthIn +: WidthIn];
        end
    end

    // Line buffers carry no reset; their contents never reach an output before
    // being overwritten by the current frame.
    always_ff @(posedge clk_i) begin
        if (in_fire) begin
            for (int c = 0; c < InChannels; c++) begin
                for (int j = 0; j < K - 2; j++) begin
                    lbuf[c][j][x_pos] <= lbuf[c][j+1][x_pos];
                end
                lbuf[c][K-2][x_pos] <= data_i[c*WidthIn +: WidthIn];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < InChannels; c++) begin
                for (int r = 0; r < K; r++) begin
                    for (int k = 0; k < K; k++) begin
                        win[c][r][k] <= '0;
                    end
                end
            end
        end else if (in_fire) begin
            for (int c = 0; c < InChannels; c++) begin
                for (int r = 0; r < K; r++) begin
                    for (int k = 0; k < K - 1; k++) begin
                        win[c][r][k] <= win[c][r][k+1];
                    end
                    win[c][r][K-1] <= col[c][r];
                end
            end
        end
    end

    // Raster position and stride phases.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_pos   <= '0;
            y_pos   <= '0;
            x_phase <= PhaseOrg;
            y_phase <= PhaseOrg;
        end else if (in_fire) begin
            if (x_end) begin
                x_pos   <= '0;
                x_phase <= PhaseOrg;
                if (y_end) begin
                    y_pos   <= '0;
                    y_phase <= PhaseOrg;
                end else begin
                    y_pos <= y_pos + YW'(1);
                    if (y_pos >= YW'(K - 1)) begin
                        y_phase <= (y_phase == PhaseMax) ? '0 : y_phase + PW'(1);
                    end
                end
            end else begin
                x_pos <= x_pos + XW'(1);
                if (x_pos >= XW'(K - 1)) begin
                    x_phase <= (x_phase == PhaseMax) ? '0 : x_phase + PW'(1);
                end
            end
        end
    end

    // Multiply-accumulate, requantize and saturate from the S1 window.
    logic signed [AccWidth-1:0] sum, sh, sat, pix, wgt;
    int idx;

    always_comb begin
        result = '0;
        sum    = '0;
        sh     = '0;
        sat    = '0;
        pix    = '0;
        wgt    = '0;
        idx    = 0;
        for (int o = 0; o < OutChannels; o++) begin
            sum = AccWidth'($signed(bias_i[o*BiasWidth +: BiasWidth]));
            for (int c = 0; c < InChannels; c++) begin
                for (int r = 0; r < K; r++) begin
                    for (int k = 0; k < K; k++) begin
                        idx = ((o * InChannels + c) * K + r) * K + k;
                        pix = AccWidth'(win[c][r][k]);
                        wgt = AccWidth'($signed(weights_i[idx*WeightWidth +: WeightWidth]));
                        sum = sum + pix * wgt;
                    end
                end
            end
            sh = sum >>> Shift;
            if (sh > SatMax) begin
                sat = SatMax;
            end else if (sh < SatMin) begin
                sat = SatMin;
            end else begin
                sat = sh;
            end
`ifdef CONV_LAYER_MC_RELU_EN
            if (sat[AccWidth-1]) begin
                sat = '0;
            end
`endif
            result[o*WidthOut +: WidthOut] = sat[WidthOut-1:0];
        end
    end

    // S1: window already captured in win; track valid and last alongside.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_s1 <= 1'b0;
            last_s1  <= 1'b0;
        end else if (ready_o) begin
            valid_s1 <= produce;
            last_s1  <= produce & at_last;
        end
    end

    // S2: registered result; holds while downstream stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_s2 <= 1'b0;
            last_s2  <= 1'b0;
            data_s2  <= '0;
        end else if (adv2) begin
            valid_s2 <= valid_s1;
            last_s2  <= last_s1;
            if (valid_s1) begin
                data_s2 <= result;
            end
        end
    end

    assign valid_o = valid_s2;
    assign last_o  = last_s2;
    assign data_o  = data_s2;

endmodule

// File: tb/tb_conv_layer_mc.sv
// Self-checking bench for conv_layer_mc using two instances:
//   dut_m: 5x4 frame, 2 in / 2 out channels, 4-bit pixels, Shift 0, Stride 1
//   dut_s: 7x6 frame, 1 in / 1 out channel, 4-bit pixels, Shift 2, Stride 2
// Expected values come from a direct convolution model over stored frames.
module tb_conv_layer_mc;

`ifdef CONV_LAYER_MC_RELU_EN
    localparam bit Relu = 1'b1;
`else
    localparam bit Relu = 1'b0;
`endif

    typedef struct {
        int d0;
        int d1;
        bit last;
        int edge_no;
    } beat_t;

    typedef struct {
        int b;
        int p;
        int w;
        int e;
    } shift_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         vi_m = 1'b0, ro_m, vo_m, lo_m;
    logic         ri_m = 1'b1;
    logic [7:0]   di_m = '0;
    logic [15:0]  do_m;
    logic [143:0] w_m = '0;
    logic [15:0]  b_m = '0;

    logic         vi_s = 1'b0, ro_s, vo_s, lo_s;
    logic         ri_s = 1'b1;
    logic [3:0]   di_s = '0;
    logic [7:0]   do_s;
    logic [35:0]  w_s = '0;
    logic [7:0]   b_s = '0;

    conv_layer_mc #(
        .LineWidthPx(5), .LineCountPx(4), .InChannels(2), .OutChannels(2), .WidthIn(4),
        .WeightWidth(4), .BiasWidth(8), .AccWidth(32), .Shift(0), .WidthOut(8),
        .KernelWidth(3), .Stride(1), .StrideOrigin(0)
    ) dut_m (
        .clk_i(clk), .rst_i(rst), .valid_i(vi_m), .ready_o(ro_m), .data_i(di_m),
        .valid_o(vo_m), .ready_i(ri_m), .last_o(lo_m), .data_o(do_m),
        .weights_i(w_m), .bias_i(b_m)
    );

    conv_layer_mc #(
        .LineWidthPx(7), .LineCountPx(6), .InChannels(1), .OutChannels(1), .WidthIn(4),
        .WeightWidth(4), .BiasWidth(8), .AccWidth(32), .Shift(2), .WidthOut(8),
        .KernelWidth(3), .Stride(2), .StrideOrigin(0)
    ) dut_s (
        .clk_i(clk), .rst_i(rst), .valid_i(vi_s), .ready_o(ro_s), .data_i(di_s),
        .valid_o(vo_s), .ready_i(ri_s), .last_o(lo_s), .data_o(do_s),
        .weights_i(w_s), .bias_i(b_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rdy_pct = 100;
    always begin
        @(posedge clk);
        #1;
        ri_m = (int'($urandom_range(99)) < rdy_pct);
    end

    int total = 0;
    int bad = 0;

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    int    frame [2][8][8];
    int    wt    [2][2][3][3];
    int    bias  [2];
    beat_t exp_q[$];
    beat_t obs_m[$];
    beat_t obs_s[$];
    int    in_edges[$];

    // Output collectors plus hold-while-stalled checks.
    beat_t       mb_m, mb_s;
    logic        hold_m = 1'b0;
    logic [15:0] hd_m;
    logic        hl_m;

    always @(negedge clk) begin
        if (rst) begin
            hold_m = 1'b0;
        end else begin
            if (hold_m) check_int("hold_m", int'(vo_m && do_m == hd_m && lo_m == hl_m), 1);
            if (vo_m && ri_m) begin
                mb_m.d0      = int'($signed(do_m[7:0]));
                mb_m.d1      = int'($signed(do_m[15:8]));
                mb_m.last    = lo_m;
                mb_m.edge_no = cyc + 1;
                obs_m.push_back(mb_m);
            end
            hold_m = vo_m && !ri_m;
            hd_m   = do_m;
            hl_m   = lo_m;
        end
    end

    always @(negedge clk) begin
        if (!rst && vo_s && ri_s) begin
            mb_s.d0      = int'($signed(do_s));
            mb_s.d1      = 0;
            mb_s.last    = lo_s;
            mb_s.edge_no = cyc + 1;
            obs_s.push_back(mb_s);
        end
    end

    // Direct convolution of the stored frame at every strided kernel position.
    task automatic model(input int w, input int h, input int cin, input int cout,
                         input int stride, input int shift);
        beat_t b;
        int first;
        first = exp_q.size();
        for (int y = 2; y < h; y += stride) begin
            for (int x = 2; x < w; x += stride) begin
                b.d0 = 0; b.d1 = 0; b.last = 1'b0; b.edge_no = 0;
                for (int o = 0; o < cout; o++) begin
                    int acc;
                    acc = bias[o];
                    for (int c = 0; c < cin; c++)
                        for (int r = 0; r < 3; r++)
                            for (int k = 0; k < 3; k++)
                                acc += frame[c][y-2+r][x-2+k] * wt[o][c][r][k];
                    acc = acc >>> shift;
                    if (acc > 127) acc = 127;
                    if (acc < -128) acc = -128;
                    if (Relu && acc < 0) acc = 0;
                    if (o == 0) b.d0 = acc; else b.d1 = acc;
                end
                exp_q.push_back(b);
            end
        end
        if (exp_q.size() > first) begin
            b = exp_q.pop_back();
            b.last = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    task automatic load_params();
        for (int o = 0; o < 2; o++)
            for (int c = 0; c < 2; c++)
                for (int r = 0; r < 3; r++)
                    for (int k = 0; k < 3; k++)
                        w_m[(((o*2+c)*3+r)*3+k)*4 +: 4] = 4'(wt[o][c][r][k]);
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                w_s[(r*3+k)*4 +: 4] = 4'(wt[0][0][r][k]);
        b_m = {8'(bias[1]), 8'(bias[0])};
        b_s = 8'(bias[0]);
    endtask

    task automatic fill_uniform(input int c, input int v);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                frame[c][y][x] = v;
    endtask

    task automatic fill_weights(input int o, input int c, input int v);
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                wt[o][c][r][k] = v;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic send_frame(input bit sel, input int w, input int h,
                              input int gap_pct, input int npix);
        int n;
        int guard;
        n = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (n < npix) begin
                    while (int'($urandom_range(99)) < gap_pct) begin
                        @(posedge clk);
                        #1;
                    end
                    if (sel) begin
                        di_s = 4'(frame[0][y][x]);
                        vi_s = 1'b1;
                    end else begin
                        di_m = {4'(frame[1][y][x]), 4'(frame[0][y][x])};
                        vi_m = 1'b1;
                    end
                    guard = 0;
                    do begin
                        @(negedge clk);
                        guard++;
                    end while (!(sel ? ro_s : ro_m) && guard < 500);
                    check_int("in_accept", int'(sel ? ro_s : ro_m), 1);
                    in_edges.push_back(cyc + 1);
                    @(posedge clk);
                    #1;
                    vi_m = 1'b0;
                    vi_s = 1'b0;
                    n++;
                end
            end
        end
    endtask

    task automatic drain(input bit sel, input int n);
        int t;
        t = 0;
        while (((sel ? obs_s.size() : obs_m.size()) < n) && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (8) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_all();
        obs_m.delete();
        obs_s.delete();
        exp_q.delete();
        in_edges.delete();
    endtask

    task automatic compare(input bit sel, input string tag);
        beat_t got[$];
        if (sel) got = obs_s; else got = obs_m;
        check_int({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            check_int({tag, "_d0"}, got[i].d0, exp_q[i].d0);
            if (!sel) check_int({tag, "_d1"}, got[i].d1, exp_q[i].d1);
            check_int({tag, "_last"}, int'(got[i].last), int'(exp_q[i].last));
        end
        clear_all();
    endtask

    shift_vec_t svec[7];

    initial begin
        svec[0] = '{b: 37,   p: 0,  w: 0,  e: 9};
        svec[1] = '{b: -37,  p: 0,  w: 0,  e: -10};
        svec[2] = '{b: 5,    p: 15, w: 7,  e: 127};
        svec[3] = '{b: -100, p: 15, w: -8, e: -128};
        svec[4] = '{b: 0,    p: 3,  w: 2,  e: 13};
        svec[5] = '{b: -1,   p: 0,  w: 0,  e: -1};
        svec[6] = '{b: 1,    p: 1,  w: 1,  e: 2};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_int("rst_valid_m", int'(vo_m), 0);
        check_int("rst_last_m", int'(lo_m), 0);
        check_int("rst_data_m", int'(do_m), 0);
        check_int("rst_ready_m", int'(ro_m), 1);
        check_int("rst_valid_s", int'(vo_s), 0);
        @(posedge clk);
        #1;

        // All-ones single-channel frame, unit weights: six 9s, last on the sixth.
        fill_uniform(0, 1);
        fill_uniform(1, 0);
        fill_weights(0, 0, 1); fill_weights(0, 1, 0);
        fill_weights(1, 0, 0); fill_weights(1, 1, 0);
        bias[0] = 0; bias[1] = 0;
        load_params();
        clear_all();
        send_frame(1'b0, 5, 4, 0, 20);
        drain(1'b0, 6);
        check_int("ones_count", obs_m.size(), 6);
        for (int i = 0; i < obs_m.size(); i++) begin
            check_int("ones_d0", obs_m[i].d0, 9);
            check_int("ones_last", int'(obs_m[i].last), int'(i == 5));
        end
        if (obs_m.size() > 0 && in_edges.size() > 12)
            check_int("ones_latency", obs_m[0].edge_no - in_edges[12], 2);
        clear_all();

        // Saturation both ways: ch0 = 5 - 270, ch1 = +270.
        fill_uniform(0, 15);
        fill_uniform(1, 15);
        fill_weights(0, 0, -1); fill_weights(0, 1, -1);
        fill_weights(1, 0, 1);  fill_weights(1, 1, 1);
        bias[0] = 5; bias[1] = 0;
        load_params();
        send_frame(1'b0, 5, 4, 0, 20);
        drain(1'b0, 6);
        check_int("sat_count", obs_m.size(), 6);
        for (int i = 0; i < obs_m.size(); i++) begin
            check_int("sat_neg", obs_m[i].d0, Relu ? 0 : -128);
            check_int("sat_pos", obs_m[i].d1, 127);
        end
        clear_all();

        // Shift/saturation table on the strided instance (uniform frames).
        for (int v = 0; v < 7; v++) begin
            int e;
            e = (Relu && svec[v].e < 0) ? 0 : svec[v].e;
            fill_uniform(0, svec[v].p);
            fill_weights(0, 0, svec[v].w);
            bias[0] = svec[v].b;
            load_params();
            send_frame(1'b1, 7, 6, 0, 42);
            drain(1'b1, 6);
            check_int("shift_count", obs_s.size(), 6);
            for (int i = 0; i < obs_s.size(); i++) begin
                check_int("shift_val", obs_s[i].d0, e);
                check_int("shift_last", int'(obs_s[i].last), int'(i == 5));
            end
            clear_all();
        end

        // Stride 2 with random content: positions {2,4,6}x{2,4}.
        for (int it = 0; it < 3; it++) begin
            for (int y = 0; y < 6; y++)
                for (int x = 0; x < 7; x++)
                    frame[0][y][x] = int'($urandom_range(15));
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    wt[0][0][r][k] = int'($urandom_range(15)) - 8;
            bias[0] = int'($urandom_range(255)) - 128;
            load_params();
            model(7, 6, 1, 1, 2, 2);
            send_frame(1'b1, 7, 6, 20, 42);
            drain(1'b1, exp_q.size());
            compare(1'b1, "stride");
        end

        // Three back-to-back random frames with random backpressure and gaps.
        for (int o = 0; o < 2; o++) begin
            for (int c = 0; c < 2; c++)
                for (int r = 0; r < 3; r++)
                    for (int k = 0; k < 3; k++)
                        wt[o][c][r][k] = int'($urandom_range(15)) - 8;
            bias[o] = int'($urandom_range(255)) - 128;
        end
        load_params();
        rdy_pct = 50;
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 2; c++)
                for (int y = 0; y < 4; y++)
                    for (int x = 0; x < 5; x++)
                        frame[c][y][x] = int'($urandom_range(15));
            model(5, 4, 2, 2, 1, 0);
            send_frame(1'b0, 5, 4, 30, 20);
        end
        drain(1'b0, exp_q.size());
        compare(1'b0, "stall");

        // Reset mid-frame while the pipeline is stalled full.
        rdy_pct = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        send_frame(1'b0, 5, 4, 0, 14);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_int("midrst_valid", int'(vo_m), 0);
        check_int("midrst_ready", int'(ro_m), 1);
        @(posedge clk);
        #1;
        rdy_pct = 100;
        @(posedge clk);
        #1;
        clear_all();
        for (int c = 0; c < 2; c++)
            for (int y = 0; y < 4; y++)
                for (int x = 0; x < 5; x++)
                    frame[c][y][x] = int'($urandom_range(15));
        model(5, 4, 2, 2, 1, 0);
        send_frame(1'b0, 5, 4, 0, 20);
        drain(1'b0, 6);
        compare(1'b0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_layer_mc.md
Name: conv_layer_mc

Overview:
- Multi-input-channel, multi-output-channel 2D convolution stage for the camera CNN pipeline; successor to the single-channel convolution layer.
- Accepts a raster stream of InChannels-wide pixels and keeps KernelWidth-1 line buffers per input channel.
- Sums every input channel against per-output-channel weights, adds a bias, requantizes by arithmetic shift with saturation, and emits through a two-stage elastic pipeline with an end-of-frame flag.

Parameters:
- LineWidthPx, 160, pixels per input line
- LineCountPx, 120, lines per frame
- InChannels, 1, input channels per pixel
- OutChannels, 1, output channels
- WidthIn, 1, unsigned bits per input channel sample
- WeightWidth, 2, signed bits per weight
- BiasWidth, 8, signed bits per bias
- AccWidth, 32, signed internal accumulator width
- Shift, 0, arithmetic right shift applied before saturation
- WidthOut, 8, signed output width per channel (WidthOut <= AccWidth)
- KernelWidth, 3, square kernel edge (>= 2)
- Stride, 1, output decimation in x and y
- StrideOrigin, 0, phase at which strided outputs are taken (< Stride)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  input pixel valid
- ready_o  out  1  input ready
- data_i  in  InChannels*WidthIn  packed pixel; channel c at bits [c*WidthIn +: WidthIn]
- valid_o  out  1  output valid
- ready_i  in  1  downstream ready
- last_o  out  1  beat is the final output of a frame; qualified by valid_o
- data_o  out  OutChannels*WidthOut  signed outputs, channel o at [o*WidthOut +: WidthOut]
- weights_i  in  OutChannels*InChannels*KernelWidth^2*WeightWidth  signed weights, order [o][c][row][col], row 0 = oldest line, col 0 = leftmost
- bias_i  in  OutChannels*BiasWidth  signed per-output bias

Behaviour:
- Reset: valid_o=0, last_o=0, data_o=0, x/y position counters=0, stride phases=StrideOrigin, windows=0, both stage valids=0. Line-buffer contents are don't-care.
- Reset mid-frame: drop all in-flight beats; the next accepted pixel is (0,0).
- in_fire = valid_i & ready_o.
  - On each in_fire: x advances. At x=LineWidthPx-1, x wraps to 0 and y increments. At the last pixel, y wraps to 0.
  - On each in_fire: every channel's window shifts left one column and loads the new right column from the line buffers. The line buffers advance on in_fire only.
- Kernel position is valid when x >= KernelWidth-1 and y >= KernelWidth-1.
  - Stride phase advances on valid-x pixels and resets at end of line.
  - y phase advances at end of a line when y is valid, and resets at end of frame.
  - produce = in_fire & kernel valid & x phase == origin & y phase == origin. Stride=1 makes both phase terms always true.
- Pipeline:
  - S1 captures the window (valid_s1 <= produce when S1 may load).
  - S2 registers the saturated result plus last (valid_s2 drives valid_o).
  - adv2 = ~valid_s2 | ready_i.
  - ready_o = ~valid_s1 | adv2.
  - S1 loads when ready_o; S2 loads S1 when adv2.
  - Unstalled latency: output valid 2 cycles after the producing in_fire. Throughput: 1 beat per cycle.
  - data_o and last_o hold stable while valid_o & ~ready_i.
- Arithmetic:
  - acc[o] = bias[o] (sign-extended) + sum over c,r,k of zero-extended pixel × signed weight, computed in AccWidth.
  - Then arithmetic right shift by Shift.
  - Saturate to [-2^(WidthOut-1), 2^(WidthOut-1)-1].
- last flag: set on the produce beat at the last pixel of the frame (x=LineWidthPx-1, y=LineCountPx-1) when that pixel produces; otherwise on the final produced beat of the frame as determined by stride.

Optional Feature:
- CONV_LAYER_MC_RELU_EN defined: after saturation, negative results become 0 on every channel.
- Undefined: signed saturated values pass through unchanged.

Test Plan:
- LineWidthPx=5, LineCountPx=4, K=3, InCh=1, WidthIn=1, all weights=1, bias=0, all-ones frame, ready_i=1 -> exactly 6 outputs, each 9; last_o only on the 6th; first valid_o 2 cycles after the 13th input (x=2, y=2).
- Same geometry, InCh=2, WidthIn=4, pixels 15, weights=-1, bias=5, WidthOut=8 -> 5-270 saturates to -128; with RELU_EN the output is 0.
- Shift=2, acc=+37 -> output 9; acc=-37 -> output -10 (arithmetic shift).
- Stride=2, StrideOrigin=0, 7x6 frame, K=3 -> 6 outputs at positions (x,y) ∈ {2,4,6}×{2,4}; last_o on output 6.
- Random ready_i (50%) and valid_i gaps over 3 back-to-back frames -> output sequence identical to the unstalled reference; data_o and last_o stable while stalled; no beat dropped or duplicated.
- Assert rst_i for 1 cycle mid-frame during a stall, then send a full frame -> valid_o=0 the cycle after reset, and the next frame yields exactly the expected 6 outputs.
